// File: rtl/line_draw_arbiter_if.sv
// line_draw_arbiter_if: client request, drawer and framebuffer signals of the line-draw arbiter.
// slave is the arbiter's view; master is the surrounding clients, drawer and framebuffer.
interface line_draw_arbiter_if #(
    parameter int NUM_REQ = 3,
    parameter int COLOR_W = 3
);
    logic [NUM_REQ-1:0]         req;
    logic [NUM_REQ*9-1:0]       req_x;
    logic [NUM_REQ*8-1:0]       req_y;
    logic [NUM_REQ*8-1:0]       req_height;
    logic [NUM_REQ*COLOR_W-1:0] req_color;
    logic [NUM_REQ-1:0]         ack;
    logic                       ld_start;
    logic [7:0]                 ld_height;
    logic [8:0]                 ld_x;
    logic [7:0]                 ld_y;
    logic                       ld_draw;
    logic                       ld_done;
    logic [8:0]                 ld_x_out;
    logic [7:0]                 ld_y_out;
    logic                       pix_we;
    logic [8:0]                 pix_x;
    logic [7:0]                 pix_y;
    logic [COLOR_W-1:0]         pix_color;
    logic                       busy;
    logic                       timeout_err;

    modport slave (
        input  req, req_x, req_y, req_height, req_color,
        input  ld_draw, ld_done, ld_x_out, ld_y_out,
        output ack, ld_start, ld_height, ld_x, ld_y,
        output pix_we, pix_x, pix_y, pix_color, busy, timeout_err
    );

    modport master (
        output req, req_x, req_y, req_height, req_color,
        output ld_draw, ld_done, ld_x_out, ld_y_out,
        input  ack, ld_start, ld_height, ld_x, ld_y,
        input  pix_we, pix_x, pix_y, pix_color, busy, timeout_err
    );
endinterface

// File: rtl/line_draw_arbiter.sv
// line_draw_arbiter: round-robin sharing of the vertical-line drawer between the pong clients.
// Latches the winner's operands, runs the drawer start/done handshake and colours its pixels.
module line_draw_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int COLOR_W = 3,
    parameter int TIMEOUT = 300
) (
    input logic clk,
    input logic reset,
    line_draw_arbiter_if.slave bus
);
    localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {IDLE, DRAW, ACK} state_t;

    state_t state, state_nx;
    logic [GW-1:0] last_grant, grant, pick, cand;
    logic found;
    int idx;
    logic [CW-1:0] cnt;
    logic [8:0] x_q;
    logic [7:0] y_q, h_q, h_clamp;
    logic [COLOR_W-1:0] c_q;
    logic timeout_err;

    logic [8:0]         rx [NUM_REQ];
    logic [7:0]         ry [NUM_REQ];
    logic [7:0]         rh [NUM_REQ];
    logic [COLOR_W-1:0] rc [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign rx[i] = bus.req_x[9*i +: 9];
        assign ry[i] = bus.req_y[8*i +: 8];
        assign rh[i] = bus.req_height[8*i +: 8];
        assign rc[i] = bus.req_color[COLOR_W*i +: COLOR_W];
    end

    // First requester above last_grant, wrapping around
    always_comb begin
        pick = last_grant;
        found = 1'b0;
        idx = 0;
        cand = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(last_grant) + k) % NUM_REQ;
            cand = GW'(idx);
            if (!found && bus.req[cand]) begin
                found = 1'b1;
                pick = cand;
            end
        end
    end

    // 255 would overflow the drawer's height+1 operand
    assign h_clamp = (rh[pick] == 8'hff) ? 8'hfe : rh[pick];

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (found) state_nx = (h_clamp != 8'd0) ? DRAW : ACK;
            DRAW:    if (bus.ld_done || cnt == CW'(TIMEOUT - 1)) state_nx = ACK;
            ACK:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            last_grant <= GW'(NUM_REQ - 1);
            grant <= '0;
            x_q <= '0;
            y_q <= '0;
            h_q <= '0;
            c_q <= '0;
            cnt <= '0;
            timeout_err <= 1'b0;
        end else begin
            state <= state_nx;
            cnt <= (state == DRAW) ? cnt + 1'b1 : '0;
            if (state == IDLE && found) begin
                grant <= pick;
                last_grant <= pick;
                x_q <= rx[pick];
                y_q <= ry[pick];
                h_q <= h_clamp;
                c_q <= rc[pick];
            end
            if (state == DRAW && !bus.ld_done && cnt == CW'(TIMEOUT - 1))
                timeout_err <= 1'b1;
        end
    end

    assign bus.ack = (state == ACK) ? NUM_REQ'(1) << grant : '0;
    assign bus.ld_start = state == DRAW;
    assign bus.ld_height = h_q + 8'd1;
    assign bus.ld_x = x_q;
    assign bus.ld_y = y_q;
    assign bus.pix_we = bus.ld_draw && state == DRAW;
    assign bus.pix_x = bus.ld_x_out;
    assign bus.pix_y = bus.ld_y_out;
    assign bus.pix_color = c_q;
    assign bus.busy = state != IDLE;
    assign bus.timeout_err = timeout_err;
endmodule

// File: tb/tb_line_draw_arbiter.sv
// tb_line_draw_arbiter: directed checks of line_draw_arbiter against a behavioural line drawer.
module tb_line_draw_arbiter;
    logic clk, reset, stuck;
    int cyc = 0;
    int passed = 0, failed = 0, total = 0;
    int pix_n, pix_bad, pix_first, bad_phase, overlap, ack_n, start_n, hmax;
    logic [8:0] ex_x;
    logic [7:0] ex_y;
    logic [2:0] ex_c;
    logic [1:0] dph;
    logic [7:0] dk, dh, dy;
    logic [8:0] dx;

    line_draw_arbiter_if #(.NUM_REQ(3), .COLOR_W(3)) b ();
    line_draw_arbiter #(.NUM_REQ(3), .COLOR_W(3), .TIMEOUT(300)) dut (.clk(clk), .reset(reset), .bus(b));

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Drawer model: h = ld_height-1 pixels on the cycles after start, then done until start drops
    always @(posedge clk) begin
        if (reset) begin
            dph <= 2'd0;
            dk <= '0;
            dh <= '0;
            dy <= '0;
            dx <= '0;
        end else begin
            case (dph)
                2'd0: if (b.ld_start) begin
                    dph <= 2'd1;
                    dk <= '0;
                    dh <= b.ld_height - 8'd1;
                    dy <= b.ld_y;
                    dx <= b.ld_x;
                end
                2'd1: begin
                    dk <= dk + 8'd1;
                    if (dk == dh - 8'd1) dph <= 2'd2;
                end
                default: if (!b.ld_start) dph <= 2'd0;
            endcase
        end
    end
    assign b.ld_draw = dph == 2'd1;
    assign b.ld_done = dph == 2'd2 && !stuck;
    assign b.ld_x_out = dx;
    assign b.ld_y_out = dy + dk;

    always @(negedge clk) begin
        if (b.pix_we) begin
            if (pix_n == 0) pix_first = cyc;
            if (b.pix_x !== ex_x || b.pix_y !== 8'(ex_y + pix_n) || b.pix_color !== ex_c) pix_bad++;
            pix_n++;
        end
        if (b.pix_we && (!b.busy || |b.ack)) bad_phase++;
        if ($countones(b.ack) > 1) overlap++;
        if (|b.ack) ack_n++;
        if (b.ld_start) begin
            start_n++;
            if (int'(b.ld_height) > hmax) hmax = int'(b.ld_height);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic clr();
        pix_n = 0; pix_bad = 0; pix_first = -1; bad_phase = 0;
        overlap = 0; ack_n = 0; start_n = 0; hmax = 0;
    endtask

    task automatic set_req(input int i, input logic [8:0] x, input logic [7:0] y,
                           input logic [7:0] h, input logic [2:0] c);
        b.req_x[9*i +: 9] = x;
        b.req_y[8*i +: 8] = y;
        b.req_height[8*i +: 8] = h;
        b.req_color[3*i +: 3] = c;
        b.req[i] = 1'b1;
    endtask

    // Returns the cycle of the first ack matching mask, or -1 if none within lim cycles
    task automatic wait_ack(input logic [2:0] m, input int lim, output int at);
        at = -1;
        for (int n = 0; n < lim; n++) begin
            if (|(b.ack & m)) begin
                at = cyc;
                break;
            end
            tick();
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        b.req = '0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        int g, a, a2;
        int at [6];
        logic [2:0] ord [6];
        reset = 1'b1;
        stuck = 1'b0;
        b.req = '0; b.req_x = '0; b.req_y = '0; b.req_height = '0; b.req_color = '0;
        ex_x = '0; ex_y = '0; ex_c = '0;
        clr();
        tick(); tick(); tick();
        chk("rst_busy", b.busy, 0);
        chk("rst_ack", b.ack, 0);
        chk("rst_start", b.ld_start, 0);
        chk("rst_we", b.pix_we, 0);
        chk("rst_terr", b.timeout_err, 0);
        chk("rst_ldx", b.ld_x, 0);
        chk("rst_ldh", b.ld_height, 1);
        reset = 1'b0;

        // single request, client 0
        clr();
        ex_x = 9'd10; ex_y = 8'd20; ex_c = 3'd5;
        set_req(0, 9'd10, 8'd20, 8'd4, 3'd5);
        g = cyc;
        tick();
        chk("t1_start", b.ld_start, 1);
        chk("t1_ldx", b.ld_x, 10);
        chk("t1_ldy", b.ld_y, 20);
        chk("t1_ldh", b.ld_height, 5);
        wait_ack(3'b001, 50, a);
        b.req = '0;
        chk("t1_ack_cyc", a, g + 7);
        chk("t1_pix_n", pix_n, 4);
        chk("t1_pix_bad", pix_bad, 0);
        chk("t1_pix_first", pix_first, g + 2);
        tick();
        chk("t1_idle", b.busy, 0);

        // all three requesting from reset
        do_reset();
        clr();
        set_req(0, 9'd100, 8'd10, 8'd2, 3'd1);
        set_req(1, 9'd200, 8'd30, 8'd2, 3'd2);
        set_req(2, 9'd300, 8'd60, 8'd2, 3'd3);
        g = cyc;
        for (int k = 0; k < 6; k++) begin
            wait_ack(3'b111, 50, at[k]);
            ord[k] = b.ack;
            if (k == 5) b.req = '0;
            tick();
        end
        chk("t2_ord0", ord[0], 3'b001);
        chk("t2_ord1", ord[1], 3'b010);
        chk("t2_ord2", ord[2], 3'b100);
        chk("t2_ord3", ord[3], 3'b001);
        chk("t2_ord4", ord[4], 3'b010);
        chk("t2_ord5", ord[5], 3'b100);
        chk("t2_first_ack", at[0], g + 5);
        chk("t2_span", at[5] - at[0], 30);
        chk("t2_pix_n", pix_n, 12);
        chk("t2_bad_phase", bad_phase, 0);
        chk("t2_overlap", overlap, 0);

        // zero-height request
        tick();
        clr();
        set_req(1, 9'd5, 8'd5, 8'd0, 3'd2);
        tick();
        chk("t3_ack", b.ack, 3'b010);
        b.req = '0;
        tick();
        chk("t3_idle", b.busy, 0);
        chk("t3_start_n", start_n, 0);
        chk("t3_pix_n", pix_n, 0);

        // height 255 clamps to 254 pixels
        clr();
        ex_x = 9'd300; ex_y = 8'd0; ex_c = 3'd6;
        set_req(2, 9'd300, 8'd0, 8'd255, 3'd6);
        g = cyc;
        wait_ack(3'b100, 400, a);
        b.req = '0;
        chk("t4_ack_cyc", a, g + 257);
        chk("t4_pix_n", pix_n, 254);
        chk("t4_pix_bad", pix_bad, 0);
        chk("t4_hmax", hmax, 255);
        tick();

        // reset in the third draw cycle
        clr();
        set_req(0, 9'd7, 8'd100, 8'd10, 3'd3);
        tick(); tick(); tick();
        chk("t5_in_draw", b.ld_start, 1);
        reset = 1'b1;
        b.req = '0;
        tick();
        chk("t5_busy", b.busy, 0);
        chk("t5_start", b.ld_start, 0);
        chk("t5_we", b.pix_we, 0);
        reset = 1'b0;
        for (int k = 0; k < 5; k++) tick();
        chk("t5_no_ack", ack_n, 0);
        clr();
        ex_x = 9'd7; ex_y = 8'd40; ex_c = 3'd4;
        set_req(0, 9'd7, 8'd40, 8'd3, 3'd4);
        g = cyc;
        wait_ack(3'b001, 50, a);
        b.req = '0;
        chk("t5_ack_cyc", a, g + 6);
        chk("t5_pix_n", pix_n, 3);
        chk("t5_pix_bad", pix_bad, 0);
        chk("t5_terr", b.timeout_err, 0);
        tick();

        // drawer never finishes; the pending client is served afterwards
        clr();
        stuck = 1'b1;
        set_req(1, 9'd20, 8'd0, 8'd5, 3'd1);
        set_req(2, 9'd30, 8'd9, 8'd1, 3'd2);
        g = cyc;
        wait_ack(3'b110, 400, a);
        chk("t6_ack1", b.ack, 3'b010);
        b.req[1] = 1'b0;
        stuck = 1'b0;
        chk("t6_ack_cyc", a, g + 301);
        chk("t6_terr", b.timeout_err, 1);
        wait_ack(3'b100, 50, a2);
        b.req = '0;
        chk("t6_next_ack", a2, a + 5);
        tick();
        chk("t6_terr_sticky", b.timeout_err, 1);
        chk("t6_idle", b.busy, 0);
        chk("t6_overlap", overlap, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
